// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame constants.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 12;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input, with a selectable reset value.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output and one-cycle framing-error / overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e          state;
    uart_state_e          state_next;
    logic                 rx_s;
    logic [TW-1:0]        tcnt;
    logic [2:0]           bidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 half_tick;
    logic                 bit_tick;
    logic                 bit_sample;
    logic                 stop_ok;
    logic                 stop_bad;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign half_tick = (tcnt == TICK_HALF);
    assign bit_tick  = (tcnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accepted stop bits leave STOP at mid-bit so a back-to-back start edge is not missed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_s) state_next = START;
            START:   if (half_tick) state_next = rx_s ? IDLE : DATA;
            DATA:    if (bit_tick && (bidx == LAST_BIT)) state_next = STOP;
            STOP:    if (bit_tick) state_next = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        bit_sample = (state == DATA) && bit_tick;
        stop_ok    = (state == STOP) && bit_tick && rx_s;
        stop_bad   = (state == STOP) && bit_tick && !rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
        end else begin
            case (state)
                START: begin
                    tcnt <= half_tick ? '0 : tcnt + TW'(1);
                    bidx <= '0;
                end
                DATA: begin
                    if (bit_sample) begin
                        tcnt        <= '0;
                        shreg[bidx] <= rx_s;
                        bidx        <= bidx + 3'd1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                STOP:    tcnt <= bit_tick ? '0 : tcnt + TW'(1);
                default: begin
                    tcnt <= '0;
                    bidx <= '0;
                end
            endcase
        end
    end

    // A completed byte is only dropped when the previous one is still waiting and not taken this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= stop_ok && valid && !ready;
            if (stop_ok) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner cases and random traffic.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 12;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #41.667 clk = ~clk;

    typedef struct {
        logic [7:0] dataByte;
        logic       stopBit;
        int         gapClocks;
        logic       expValid;
        logic       expFerr;
    } frame_vec_t;

    frame_vec_t vecs[8];

    int         checks      = 0;
    int         failures    = 0;
    int         validCycles = 0;
    int         ferrCount   = 0;
    int         ovrCount    = 0;
    int         exclErr     = 0;
    int         stableErr   = 0;
    logic [7:0] rxQueue[$];
    logic [7:0] modelQueue[$];
    logic       prevValid   = 1'b0;
    logic       prevReady   = 1'b0;
    logic [7:0] prevData    = 8'h00;

    // Observes the byte interface between edges and records every handshake and pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) rxQueue.push_back(data);
            if (valid) validCycles++;
            if (frame_err) ferrCount++;
            if (overrun) ovrCount++;
            if (frame_err && overrun) exclErr++;
            if (prevValid && !prevReady && valid && (data != prevData)) stableErr++;
        end
        prevValid = valid;
        prevReady = ready;
        prevData  = data;
    end

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic driveBit(input logic b);
        rx = b;
        waitClocks(CPB);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
        driveBit(stopBit);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkNextByte(input string name, input logic [7:0] expected);
        int n;
        n = rxQueue.size();
        checkOutput({name, " byte count"}, n, 1);
        if (n > 0) checkOutput({name, " data"}, rxQueue.pop_front(), expected);
        rxQueue.delete();
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, " valid"}, valid, 0);
        checkOutput({name, " data"}, data, 0);
        checkOutput({name, " frame_err"}, frame_err, 0);
        checkOutput({name, " overrun"}, overrun, 0);
        checkOutput({name, " busy"}, busy, 0);
    endtask

    initial begin
        int vc0, fe0, ov0, gap;
        logic [7:0] b;
        logic [7:0] partial;
        logic       stopBit;

        vecs[0] = '{8'h31, 1'b1, 24, 1'b1, 1'b0};
        vecs[1] = '{8'h55, 1'b1,  0, 1'b1, 1'b0};
        vecs[2] = '{8'hAA, 1'b1, 24, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 12, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b1,  0, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 24, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 1'b0, 36, 1'b0, 1'b1};
        vecs[7] = '{8'h01, 1'b1, 24, 1'b1, 1'b0};

        waitClocks(3);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        ready = 1'b1;
        waitClocks(24);

        for (int i = 0; i < 8; i++) begin
            vc0 = validCycles;
            fe0 = ferrCount;
            ov0 = ovrCount;
            applyStimulus(vecs[i].dataByte, vecs[i].stopBit);
            rx = 1'b1;
            waitClocks(vecs[i].gapClocks);
            if (vecs[i].expValid) begin
                checkNextByte($sformatf("vec%0d", i), vecs[i].dataByte);
            end else begin
                checkOutput($sformatf("vec%0d no byte", i), rxQueue.size(), 0);
                rxQueue.delete();
            end
            checkOutput($sformatf("vec%0d valid cycles", i), validCycles - vc0, {31'd0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d frame_err", i), ferrCount - fe0, {31'd0, vecs[i].expFerr});
            checkOutput($sformatf("vec%0d overrun", i), ovrCount - ov0, 0);
        end

        // Short low glitch on the line must be rejected at the start-bit midpoint.
        vc0 = validCycles;
        rx = 1'b0;
        waitClocks(4);
        rx = 1'b1;
        checkOutput("glitch busy high", busy, 1);
        waitClocks(8);
        checkOutput("glitch busy low", busy, 0);
        checkOutput("glitch no valid", validCycles - vc0, 0);
        applyStimulus(8'h5A, 1'b1);
        waitClocks(24);
        checkNextByte("after glitch", 8'h5A);

        // Low stop bit followed by a held-low line.
        vc0 = validCycles;
        fe0 = ferrCount;
        applyStimulus(8'h0F, 1'b0);
        waitClocks(5 * CPB);
        checkOutput("break frame_err", ferrCount - fe0, 1);
        checkOutput("break no valid", validCycles - vc0, 0);
        checkOutput("break busy", busy, 1);
        rx = 1'b1;
        waitClocks(24);
        checkOutput("break exit busy", busy, 0);
        applyStimulus(8'h3C, 1'b1);
        waitClocks(24);
        checkNextByte("after break", 8'h3C);
        checkOutput("break single frame_err", ferrCount - fe0, 1);

        // Consumer stalled across two frames.
        ready = 1'b0;
        ov0 = ovrCount;
        fe0 = ferrCount;
        applyStimulus(8'h11, 1'b1);
        waitClocks(12);
        applyStimulus(8'h22, 1'b1);
        waitClocks(12);
        checkOutput("overrun valid held", valid, 1);
        checkOutput("overrun old data", data, 8'h11);
        checkOutput("overrun pulses", ovrCount - ov0, 1);
        checkOutput("overrun no frame_err", ferrCount - fe0, 0);
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        checkOutput("overrun consumed", valid, 0);
        checkNextByte("overrun handshake", 8'h11);
        ready = 1'b1;
        waitClocks(12);

        // Reset during bit 4 of 0xC3 abandons the frame silently.
        vc0 = validCycles;
        fe0 = ferrCount;
        partial = 8'hC3;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(partial[i]);
        rx = partial[4];
        waitClocks(6);
        checkOutput("midframe busy", busy, 1);
        rst_n = 1'b0;
        waitClocks(2);
        checkResetOutputs("midframe reset");
        rx = 1'b1;
        waitClocks(3);
        rst_n = 1'b1;
        waitClocks(24);
        checkOutput("post reset busy", busy, 0);
        applyStimulus(8'h7E, 1'b1);
        waitClocks(24);
        checkNextByte("after reset", 8'h7E);
        checkOutput("after reset valid cycles", validCycles - vc0, 1);
        checkOutput("after reset frame_err", ferrCount - fe0, 0);

        // Random traffic against a byte-level reference: good frames deliver in order, bad stops deliver nothing.
        for (int i = 0; i < 16; i++) begin
            b       = 8'($urandom_range(0, 255));
            stopBit = ($urandom_range(0, 3) != 0);
            gap     = int'($urandom_range(0, 20));
            if (!stopBit) gap = gap + CPB;
            fe0 = ferrCount;
            if (stopBit) modelQueue.push_back(b);
            applyStimulus(b, stopBit);
            rx = 1'b1;
            waitClocks(gap);
            if (stopBit) begin
                checkNextByte($sformatf("rand%0d", i), modelQueue.pop_front());
            end else begin
                checkOutput($sformatf("rand%0d no byte", i), rxQueue.size(), 0);
                rxQueue.delete();
            end
            checkOutput($sformatf("rand%0d frame_err", i), ferrCount - fe0, {31'd0, !stopBit});
        end

        checkOutput("pulse exclusivity", exclErr, 0);
        checkOutput("data stable while valid", stableErr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the FPGA top level: 8N1 frames, LSB first, line idle high.
- Recovers bytes from the asynchronous serial input pin and presents them on a valid/ready byte interface to the command logic.
- Default timing: 12 MHz system clock, 1 Mbaud, so one bit lasts 12 clocks.
- Reports framing errors and overruns as one-cycle pulses.

Parameters:
- CLKS_PER_BIT, 12, system clocks per bit period; must be at least 4.
- SYNC_STAGES, 2, synchroniser flops on the rx pin; must be at least 2.

Ports:
- clk  in  1  system clock (12 MHz nominal).
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx  in  1  serial line, asynchronous to clk, idle high.
- data  out  8  received byte; stable while valid is high.
- valid  out  1  byte available.
- ready  in  1  consumer accepts the byte when valid && ready at a rising clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: new byte completed while the previous byte was unaccepted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, all counters 0, synchroniser flops to 1, data=0, valid=0, frame_err=0, overrun=0, busy=0. Reset mid-frame abandons the frame; no pulses are generated.
- Synchroniser: rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Tick counter: tcnt, width clog2(CLKS_PER_BIT). Bit index: bidx, 3 bits. Shift register: 8 bits, LSB first.
- IDLE: when rx_s==0, go to START and clear tcnt.
- START: increment tcnt. When tcnt == CLKS_PER_BIT/2-1, sample rx_s:
  - rx_s==1: glitch. Return to IDLE with no output.
  - rx_s==0: go to DATA with tcnt=0 and bidx=0.
- DATA: when tcnt == CLKS_PER_BIT-1, shift rx_s into bit[bidx], clear tcnt, increment bidx. After bit 7 is sampled, go to STOP.
- STOP: when tcnt == CLKS_PER_BIT-1, sample rx_s:
  - rx_s==1: frame accepted; go to IDLE on the next cycle. This is half a bit early, to allow resync on back-to-back frames.
  - rx_s==0: frame_err=1 for one cycle, byte discarded, go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. A held-low line therefore never produces repeated frames.
- Output register, applied on the accepted-stop cycle edge:
  - valid==0, or valid && ready: data <= shift register, valid <= 1.
  - valid && !ready: overrun=1 for one cycle; the old data and valid are retained and the new byte is dropped.
- Consumption: valid && ready with no completing frame clears valid on the next edge.
- Latency: valid rises 1 clock after the stop-bit sample edge. The stop-bit sample is about SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after the rx falling edge.
- frame_err and overrun are mutually exclusive in any cycle.
- busy is combinational from state (state != IDLE).

Decomposition:
- Shared package `uart_pkg`:
  - state enum: IDLE, START, DATA, STOP, BREAK.
  - localparams: DATA_BITS=8 and the default CLKS_PER_BIT.
  - The package is also used by a later `uart_tx`.
- One natural sub-module, `sync_ff`: the parameterised SYNC_STAGES synchroniser with a reset value parameter. It is reusable for other pin inputs.

Test Plan:
All tests use 12 MHz clk and a 1000 ns bit time.
1. Send 0x31 with ready held high -> valid pulses for exactly 1 cycle with data==0x31; frame_err=0, overrun=0.
2. Send 0x55 then 0xAA back-to-back with no idle gap, ready=1 -> two valid cycles with data 0x55 then 0xAA, no errors.
3. Drive rx low for 300 ns (under half a bit), then high -> no valid, busy returns to 0 within 8 clocks of the sample point, and a following 0x5A frame is received correctly.
4. Send 0x0F with the stop bit forced low, then hold low for 5 bit times, then high -> frame_err pulses once, valid stays 0, no further frames while low, and the next 0x3C is received.
5. ready=0; send 0x11 then 0x22 -> valid=1 with data==0x11, one overrun pulse at the 0x22 stop sample; after ready=1 for one cycle, valid=0.
6. Assert rst_n low mid-byte (during bit 4 of 0xC3), release, then send 0x7E -> all outputs 0 during reset, no spurious valid or frame_err, and 0x7E is received correctly.
